// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, LSB first,
// with a start/busy/done handshake toward the requester.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sha_reg;
    logic [WIDTH-1:0] shb_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;

    full_adder u_fa (
        .a    (sha_reg[0]),
        .b    (shb_reg[0]),
        .cin  (carry_reg),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    // New result bit enters at the MSB so after WIDTH steps bit 0 sits at LSB.
    assign acc_next = {fa_sum, acc_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sha_reg   <= '0;
            shb_reg   <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sha_reg   <= a;
                        shb_reg   <= b;
                        carry_reg <= cin;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    sha_reg   <= sha_reg >> 1;
                    shb_reg   <= shb_reg >> 1;
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_BIT) begin
                        sum_reg   <= acc_next;
                        cout_reg  <= fa_cout;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: 8-bit and 16-bit instances checked every cycle
// against a countdown/arithmetic model, plus directed literal expectations.

module tb_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_add_ctrl #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    // Reference: accepted add = plain integer sum; outputs appear WIDTH edges later.
    logic [15:0] in_a [2];
    logic [15:0] in_b [2];
    logic        in_c [2];
    logic        in_s [2];
    assign in_a[0] = {8'h00, a8};
    assign in_a[1] = a16;
    assign in_b[0] = {8'h00, b8};
    assign in_b[1] = b16;
    assign in_c[0] = cin8;
    assign in_c[1] = cin16;
    assign in_s[0] = start8;
    assign in_s[1] = start16;

    int          m_left [2];
    logic [16:0] m_res  [2];
    logic [15:0] m_sum  [2];
    logic        m_cout [2];
    logic        m_done [2];

    function automatic int width_of(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_left[i] <= 0;
                m_res[i]  <= '0;
                m_sum[i]  <= '0;
                m_cout[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_sum[i]  <= 16'(m_res[i] & ((17'd1 << width_of(i)) - 17'd1));
                        m_cout[i] <= m_res[i][width_of(i)];
                        m_done[i] <= 1'b1;
                    end
                end else if (in_s[i]) begin
                    m_res[i]  <= 17'(in_a[i]) + 17'(in_b[i]) + 17'(in_c[i]);
                    m_left[i] <= width_of(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare point: every negedge, both instances against the model.
    task automatic tick();
        @(negedge clk);
        chk("busy8",  32'(busy8),  32'(m_left[0] != 0));
        chk("done8",  32'(done8),  32'(m_done[0]));
        chk("sum8",   32'(sum8),   32'(m_sum[0][7:0]));
        chk("cout8",  32'(cout8),  32'(m_cout[0]));
        chk("busy16", 32'(busy16), 32'(m_left[1] != 0));
        chk("done16", 32'(done16), 32'(m_done[1]));
        chk("sum16",  32'(sum16),  32'(m_sum[1]));
        chk("cout16", 32'(cout16), 32'(m_cout[1]));
    endtask

    // One 8-bit add with literal expectations; optionally disturb inputs mid-run.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] esum, input logic ecout, input bit disturb);
        logic [7:0] old_sum;
        int busy_cnt;
        int n_done;
        bit seen;
        old_sum = sum8;
        a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (disturb && t == 3) begin
                start8 = 1'b1; a8 = ~va; b8 = ~vb; cin8 = ~vc;
            end
            if (disturb && t == 4) start8 = 1'b0;
            tick();
            if (done8) seen = 1;
            else begin
                if (busy8) busy_cnt++;
                chk("sum_hold", 32'(sum8), 32'(old_sum));
            end
        end
        start8 = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'd8);
        chk("sum_lit", 32'(sum8), 32'(esum));
        chk("cout_lit", 32'(cout8), 32'(ecout));
        n_done = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (done8) n_done++;
        end
        chk("no_extra_done", 32'(n_done), 32'd0);
    endtask

    initial begin
        int t, t1, n_done;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);

        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 0);
        run8(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1);

        // Back-to-back with start held high.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h80; b8 = 8'h80;
        t = 0; t1 = 0; n_done = 0;
        while (t < 40 && n_done < 2) begin
            tick();
            t++;
            if (done8) begin
                n_done++;
                if (n_done == 1) begin
                    t1 = t;
                    chk("b2b_sum1", 32'(sum8), 32'h30);
                    chk("b2b_cout1", 32'(cout8), 32'd0);
                    chk("b2b_busy_in_done", 32'(busy8), 32'd0);
                end else begin
                    chk("b2b_gap", 32'(t - t1), 32'd9);
                    chk("b2b_sum2", 32'(sum8), 32'h00);
                    chk("b2b_cout2", 32'(cout8), 32'd1);
                end
            end
            if (n_done == 1 && t == t1 + 1) begin
                chk("b2b_reaccept", 32'(busy8), 32'd1);
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        chk("b2b_dones", 32'(n_done), 32'd2);
        repeat (20) tick();

        // Asynchronous reset in the middle of an add.
        a8 = 8'hC3; b8 = 8'h7E; start8 = 1'b1;
        a16 = 16'hBEEF; b16 = 16'h1234; start16 = 1'b1;
        tick();
        start8 = 1'b0; start16 = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy8", 32'(busy8), 32'd0);
        chk("arst_done8", 32'(done8), 32'd0);
        chk("arst_sum8", 32'(sum8), 32'd0);
        chk("arst_cout8", 32'(cout8), 32'd0);
        chk("arst_busy16", 32'(busy16), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8 || done16) n_done++;
        end
        chk("arst_no_done", 32'(n_done), 32'd0);
        run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

        // Random traffic on both widths; model checks every cycle.
        for (int k = 0; k < 22000; k++) begin
            start8  = ($urandom_range(0, 3) != 0);
            start16 = ($urandom_range(0, 3) != 0);
            a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            tick();
        end
        start8 = 1'b0; start16 = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
